pacman_motion_ctrl: RTL
=======================

// Module: pacman_motion_ctrl
// PURPOSE
//   Player movement controller directly upstream of collision_detection. Latches the player's
//   requested direction, drives the probe direction plus current p_x/p_y into the detector,
//   samples its collide flag, then commits one STEP of movement per move tick.
//   Turns are buffered: a request blocked by a wall is held and retried on later ticks.
// PARAMETERS
//   START_X  9'd160  p_x after reset (sprite centre, map pixel units)
//   START_Y  9'd200  p_y after reset
//   STEP     4'd1    pixels moved per committed tick
//   SETTLE   2'd2    cycles from a probe_dir/position change to valid collide (det reg + ROM)
//   X_MIN    9'd12   left tunnel edge; a left move below it wraps to X_MAX
//   X_MAX    9'd307  right tunnel edge; a right move above it wraps to X_MIN
// PORTS
//   clk        in   1  system clock
//   rst        in   1  reset, synchronous, active-high
//   tick       in   1  move-enable pulse, 1 cycle wide
//   key_dir    in   4  requested direction, one-hot: 1000 left, 0100 up, 0010 right, 0001 down
//   collide    in   1  from collision_detection; 1 = wall ahead in probe_dir
//   probe_dir  out  4  direction driven to collision_detection
//   p_x        out  9  player x (also drives collision_detection)
//   p_y        out  9  player y
//   cur_dir    out  4  committed travel direction (for sprite orientation)
//   moving     out  1  1 = last tick produced a step
//   busy       out  1  1 = state != IDLE
//   tick_drop  out  1  1-cycle pulse: a tick arrived while busy and was ignored
// BEHAVIOUR
//   Clock and reset
//     Single clock domain. Reset is synchronous and active-high.
//     Reset values: p_x=START_X, p_y=START_Y, cur_dir=1000, req_dir=0000, probe_dir=1000,
//       moving=0, busy=0, tick_drop=0, state=IDLE.
//     rst asserted in any state aborts the operation; all reset values apply at the next edge.
//   Request latch
//     key_dir is captured into req_dir only when exactly one bit is set.
//     Zero or multi-hot values are ignored; req_dir keeps its previous value.
//   State machine
//     IDLE
//       probe_dir=cur_dir.
//       On tick: if req_dir!=0 and req_dir!=cur_dir, snapshot snap=req_dir, go PROBE_REQ;
//       otherwise go PROBE_CUR.
//     PROBE_REQ
//       probe_dir=snap; hold for SETTLE cycles (counter), then go CHECK_REQ.
//     CHECK_REQ
//       Sample collide.
//       If collide=0: cur_dir<=snap, and req_dir<=0 unless a new valid key arrives this cycle
//         (the new key wins). Then go MOVE.
//       If collide=1: go PROBE_CUR; req_dir is kept for later ticks.
//     PROBE_CUR
//       probe_dir=cur_dir; hold for SETTLE cycles, then go CHECK_CUR.
//     CHECK_CUR
//       collide=0: go MOVE.
//       collide=1: moving<=0, go IDLE; position unchanged.
//     MOVE
//       One edge: p_x/p_y step by STEP in cur_dir, moving<=1, go IDLE.
//   Timing
//     Tick at cycle T with the turn free: position updates at the edge ending cycle T+2+SETTLE.
//     Turn blocked: worst case, position updates at the edge ending cycle T+3+2*SETTLE.
//   Arithmetic (9-bit, unsigned)
//     left:  p_x<X_MIN+STEP ? X_MAX : p_x-STEP     right: p_x+STEP>X_MAX ? X_MIN : p_x+STEP
//     up/down: p_y-STEP / p_y+STEP, no wrap (the map walls bound y).
//   Boundary cases
//     A reverse request (opposite of cur_dir) is probed like any other turn.
//     key_dir changes during PROBE_* update req_dir but not snap or probe_dir.
//     tick while busy: ignored and pulses tick_drop; simultaneous tick and rst: reset wins.
//     p_x/p_y never change outside MOVE, so the detector inputs stay stable while probing.
// TESTING
//   1 Reset, then hold rst mid-PROBE_REQ
//     -> p_x=160, p_y=200, cur_dir=1000, busy=0 on the next edge.
//   2 Open corridor, no key, collide=0, one tick
//     -> p_x 160->159 exactly SETTLE+3 cycles after the tick; moving=1.
//   3 key_dir=0001 with collide=1 on the down probe and 0 on the left probe
//     -> moves left; req_dir stays 0001.
//     Next tick with down free -> cur_dir=0001, p_y+1, req_dir=0.
//   4 Wall both ways (collide=1 always), tick
//     -> p_x/p_y unchanged, moving=0, busy back to 0.
//   5 Wrap: p_x=12 moving left
//     -> p_x=307. p_x=307 moving right -> p_x=12.
//   6 Second tick 2 cycles after the first
//     -> tick_drop pulses once; only one step is taken. key_dir=0110 -> ignored.

Source files
------------

// File: rtl/pacman_motion_ctrl_if.sv
// Signal bundle between the player motion controller and its environment
// (key input, move tick, collision detector and sprite/position consumers).
interface pacman_motion_ctrl_if;
    logic       tick;
    logic [3:0] key_dir;
    logic       collide;
    logic [3:0] probe_dir;
    logic [8:0] p_x;
    logic [8:0] p_y;
    logic [3:0] cur_dir;
    logic       moving;
    logic       busy;
    logic       tick_drop;

    modport master (
        output tick, key_dir, collide,
        input  probe_dir, p_x, p_y, cur_dir, moving, busy, tick_drop
    );

    modport slave (
        input  tick, key_dir, collide,
        output probe_dir, p_x, p_y, cur_dir, moving, busy, tick_drop
    );
endinterface

// File: rtl/pacman_motion_ctrl.sv
// Player movement controller: buffers the requested turn, probes the collision
// detector for the turn and then the current heading, and commits one step per tick.
//
// state     | meaning
// IDLE      | waiting for tick, probing cur_dir
// PROBE_REQ | probing the buffered turn, waiting for detector to settle
// CHECK_REQ | sampling collide for the turn; commit turn if free
// PROBE_CUR | probing current heading, waiting for detector to settle
// CHECK_CUR | sampling collide for the heading
// MOVE      | commit one step in cur_dir
module pacman_motion_ctrl #(
    parameter logic [8:0] START_X = 9'd160,
    parameter logic [8:0] START_Y = 9'd200,
    parameter logic [3:0] STEP    = 4'd1,
    parameter logic [1:0] SETTLE  = 2'd2,
    parameter logic [8:0] X_MIN   = 9'd12,
    parameter logic [8:0] X_MAX   = 9'd307
) (
    input  logic                 clk,
    input  logic                 rst,
    pacman_motion_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_PROBE_REQ, S_CHECK_REQ, S_PROBE_CUR, S_CHECK_CUR, S_MOVE
    } state_t;

    localparam logic [3:0] DIR_L = 4'b1000;
    localparam logic [3:0] DIR_U = 4'b0100;
    localparam logic [3:0] DIR_R = 4'b0010;
    localparam logic [3:0] DIR_D = 4'b0001;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_cnt;
    logic [3:0] r_req;
    logic [3:0] r_snap;
    logic [3:0] r_cur;
    logic [8:0] r_x;
    logic [8:0] r_y;
    logic       r_moving;
    logic       r_tick_drop;
    logic       w_key_ok;
    logic       w_turn;
    logic       w_probing;
    logic [8:0] w_step;

    assign w_key_ok  = (bus.key_dir != 4'd0) && ((bus.key_dir & (bus.key_dir - 4'd1)) == 4'd0);
    assign w_turn    = (r_req != 4'd0) && (r_req != r_cur);
    assign w_probing = (r_state == S_PROBE_REQ) || (r_state == S_PROBE_CUR);
    assign w_step    = {5'd0, STEP};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (bus.tick) w_next = w_turn ? S_PROBE_REQ : S_PROBE_CUR;
            S_PROBE_REQ: if (r_cnt == 2'd0) w_next = S_CHECK_REQ;
            S_CHECK_REQ: w_next = bus.collide ? S_PROBE_CUR : S_MOVE;
            S_PROBE_CUR: if (r_cnt == 2'd0) w_next = S_CHECK_CUR;
            S_CHECK_CUR: w_next = bus.collide ? S_IDLE : S_MOVE;
            S_MOVE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.probe_dir = r_cur;
        bus.busy      = (r_state != S_IDLE);
        if ((r_state == S_PROBE_REQ) || (r_state == S_CHECK_REQ))
            bus.probe_dir = r_snap;
    end

    // Settle counter reloads whenever not probing, so every PROBE_* entry starts fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= SETTLE - 2'd1;
            r_req       <= 4'd0;
            r_snap      <= DIR_L;
            r_cur       <= DIR_L;
            r_x         <= START_X;
            r_y         <= START_Y;
            r_moving    <= 1'b0;
            r_tick_drop <= 1'b0;
        end else begin
            r_tick_drop <= bus.tick && (r_state != S_IDLE);
            r_cnt       <= w_probing ? (r_cnt - 2'd1) : (SETTLE - 2'd1);
            if (w_key_ok) r_req <= bus.key_dir;
            case (r_state)
                S_IDLE: begin
                    if (bus.tick && w_turn) r_snap <= r_req;
                end
                S_CHECK_REQ: begin
                    if (!bus.collide) begin
                        r_cur <= r_snap;
                        if (!w_key_ok) r_req <= 4'd0;
                    end
                end
                S_CHECK_CUR: begin
                    if (bus.collide) r_moving <= 1'b0;
                end
                S_MOVE: begin
                    r_moving <= 1'b1;
                    case (r_cur)
                        DIR_L: r_x <= (r_x < X_MIN + w_step) ? X_MAX : (r_x - w_step);
                        DIR_R: r_x <= (r_x + w_step > X_MAX) ? X_MIN : (r_x + w_step);
                        DIR_U: r_y <= r_y - w_step;
                        DIR_D: r_y <= r_y + w_step;
                        default: r_x <= r_x;
                    endcase
                end
                default: r_cnt <= r_cnt - 2'd1;
            endcase
        end
    end

    assign bus.p_x       = r_x;
    assign bus.p_y       = r_y;
    assign bus.cur_dir   = r_cur;
    assign bus.moving    = r_moving;
    assign bus.tick_drop = r_tick_drop;
endmodule
